// File: rtl/rom_read_cache.sv
// rtl/rom_read_cache.sv - direct-mapped single-word read cache in front of the SDRAM romrd port
//
// Purpose: caches 16-bit ROM words for the cartridge bus so repeated reads are served
// in 2 clk without an SDRAM access. Misses fill over the romrd toggle handshake.
// Optional feature macro: ROMCACHE_PREFETCH_EN (after each fill, fetch the next word).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   invalidate      1-clk pulse, drops every cached line (acted on when idle)
//   cpu_req/cpu_ack toggle handshake from the CPU side, cpu_a word address, cpu_q data
//   romrd_req/ack   toggle handshake to SDRAM, romrd_a fill address, romrd_q fill data
//   hit_cnt         saturating hit counter (debug)
module rom_read_cache #(
  parameter int LINES  = 64,
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              invalidate,
  input  logic              cpu_req,
  output logic              cpu_ack,
  input  logic [ADDR_W-1:0] cpu_a,
  output logic [15:0]       cpu_q,
  output logic              romrd_req,
  input  logic              romrd_ack,
  output logic [ADDR_W-1:0] romrd_a,
  input  logic [15:0]       romrd_q,
  output logic [15:0]       hit_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

`ifdef ROMCACHE_PREFETCH_EN
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_FILL, S_PREF} state_t;
`else
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_FILL} state_t;
`endif

  state_t             state;
  logic [IDX_W-1:0]   clr_cnt;
  logic               inv_pend;

  logic               valid    [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [15:0]        data_mem [LINES];

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [15:0]        rd_data;
  logic [IDX_W-1:0]   rd_idx;

  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               romrd_done;
  logic               fill_wr;
  logic               hit;
  logic               inv_now;

  assign cpu_idx    = cpu_a[IDX_W-1:0];
  assign cpu_tag    = cpu_a[ADDR_W-1:IDX_W];
  assign fill_idx   = romrd_a[IDX_W-1:0];
  assign fill_tag   = romrd_a[ADDR_W-1:IDX_W];
  assign romrd_done = (romrd_ack == romrd_req);
  assign hit        = rd_valid && (rd_tag == cpu_tag);
  // An invalidate seen now or earlier means a completing fill must not mark its line valid.
  assign inv_now    = inv_pend || invalidate;

`ifdef ROMCACHE_PREFETCH_EN
  logic               pf_busy;
  logic [ADDR_W-1:0]  pf_a;
  assign pf_a = romrd_a + {{(ADDR_W-1){1'b0}}, 1'b1};
  // While filling, look up the next line so PREF can decide in its first clock.
  assign rd_idx  = (state == S_FILL) ? pf_a[IDX_W-1:0] : cpu_idx;
  assign fill_wr = romrd_done && ((state == S_FILL) || (state == S_PREF && pf_busy));
`else
  assign rd_idx  = cpu_idx;
  assign fill_wr = romrd_done && (state == S_FILL);
`endif

  // Tag/data storage: synchronous read every clock, written at the fill address.
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= romrd_q;
    end
    rd_tag  <= tag_mem[rd_idx];
    rd_data <= data_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    rd_valid <= valid[rd_idx];
    if (invalidate) inv_pend <= 1'b1;
    if (reset) begin
      cpu_ack   <= cpu_req;
      romrd_req <= romrd_ack;
      cpu_q     <= '0;
      romrd_a   <= '0;
      hit_cnt   <= '0;
      clr_cnt   <= '0;
      inv_pend  <= 1'b0;
      state     <= S_CLEAR;
`ifdef ROMCACHE_PREFETCH_EN
      pf_busy   <= 1'b0;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          valid[clr_cnt] <= 1'b0;
          clr_cnt        <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) state <= S_IDLE;
        end
        S_IDLE: begin
          if (inv_now) begin
            inv_pend <= 1'b0;
            clr_cnt  <= '0;
            state    <= S_CLEAR;
          end else if (cpu_req != cpu_ack) begin
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_q   <= rd_data;
            cpu_ack <= cpu_req;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state   <= S_IDLE;
          end else begin
            romrd_a   <= cpu_a;
            romrd_req <= ~romrd_req;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (romrd_done) begin
            if (!inv_now) valid[fill_idx] <= 1'b1;
            cpu_q   <= romrd_q;
            cpu_ack <= cpu_req;
`ifdef ROMCACHE_PREFETCH_EN
            pf_busy <= 1'b0;
            state   <= S_PREF;
`else
            state   <= S_IDLE;
`endif
          end
        end
`ifdef ROMCACHE_PREFETCH_EN
        S_PREF: begin
          if (!pf_busy) begin
            if (rd_valid && rd_tag == pf_a[ADDR_W-1:IDX_W]) begin
              state <= S_IDLE;
            end else begin
              romrd_a   <= pf_a;
              romrd_req <= ~romrd_req;
              pf_busy   <= 1'b1;
            end
          end else if (romrd_done) begin
            if (!inv_now) valid[fill_idx] <= 1'b1;
            // A waiting CPU read of the prefetched word is answered straight from the fill.
            if (cpu_req != cpu_ack && cpu_a == romrd_a) begin
              cpu_q   <= romrd_q;
              cpu_ack <= cpu_req;
            end
            pf_busy <= 1'b0;
            state   <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
